// File: rtl/y_gate_stream_pkg.sv
// Shared definitions for the SSM output side: fp16 constants, FSM states and
// the flat element-index helper used by the SSM-side blocks.
package y_gate_stream_pkg;
  localparam int DW = 16;
  localparam logic [15:0] POS_ZERO = 16'h0000;
  localparam logic [15:0] ONE      = 16'h3C00;
  localparam logic [15:0] QNAN     = 16'h7E00;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  function automatic int elem_idx(input int b, input int h, input int p,
                                  input int n_h, input int n_p);
    return (b * n_h + h) * n_p + p;
  endfunction
endpackage

// File: rtl/fp16_mul.sv
// IEEE fp16 multiplier, round-to-nearest-even, subnormals supported.
// Fixed latency of M_LAT cycles; the pipeline never stalls.
module fp16_mul
  import y_gate_stream_pkg::*;
#(
  parameter int M_LAT = 6
) (
  input  logic          clk,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] p
);
  function automatic logic [15:0] fp16_mul_rne(input logic [15:0] x, input logic [15:0] y);
    logic        s;
    logic [4:0]  ex, ey;
    logic [10:0] sx, sy;
    logic [21:0] prod, mask;
    logic [14:0] mag;
    logic        sticky, inc;
    int          lead, e, sh;
    s  = x[15] ^ y[15];
    ex = x[14:10];
    ey = y[14:10];
    if ((ex == 5'd31 && x[9:0] != 10'd0) || (ey == 5'd31 && y[9:0] != 10'd0)) return QNAN;
    if (ex == 5'd31 || ey == 5'd31) begin
      if (x[14:0] == 15'd0 || y[14:0] == 15'd0) return QNAN;
      return {s, 15'h7C00};
    end
    if (x[14:0] == 15'd0 || y[14:0] == 15'd0) return {s, 15'd0};
    sx   = {(ex != 5'd0), x[9:0]};
    sy   = {(ey != 5'd0), y[9:0]};
    prod = {11'd0, sx} * {11'd0, sy};
    lead = 0;
    for (int i = 0; i < 22; i++) if (prod[i]) lead = i;
    e = lead + ((ex == 5'd0) ? 1 : int'(ex)) + ((ey == 5'd0) ? 1 : int'(ey)) - 35;
    if (e >= 31) return {s, 15'h7C00};
    prod   = prod << (21 - lead);
    sticky = 1'b0;
    // Results below the normal range are denormalised before rounding
    if (e < 1) begin
      sh = 1 - e;
      if (sh > 21) begin
        sticky = |prod;
        prod   = 22'd0;
      end else begin
        mask   = (22'd1 << sh) - 22'd1;
        sticky = |(prod & mask);
        prod   = prod >> sh;
      end
      e = 0;
    end
    sticky = sticky | (|prod[9:0]);
    inc    = prod[10] & (sticky | prod[11]);
    mag    = {5'(e), prod[20:11]} + {14'd0, inc};
    return {s, mag};
  endfunction

  logic [DW-1:0] prod_d;
  logic [DW-1:0] pipe_q [M_LAT];

  always_comb prod_d = fp16_mul_rne(a, b);

  always_ff @(posedge clk) begin
    pipe_q[0] <= prod_d;
    for (int i = 1; i < M_LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign p = pipe_q[M_LAT-1];
endmodule

// File: rtl/y_gate_fifo.sv
// First-word-fall-through FIFO with occupancy count; dout is the head entry.
// Push while full is accepted only together with a pop.
module y_gate_fifo
  import y_gate_stream_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/y_gate_stream.sv
// Captures the SSM y vector on start, multiplies each element by its gate
// value and streams the products out in index order through a credited FIFO.
module y_gate_stream
  import y_gate_stream_pkg::*;
#(
  parameter int B     = 1,
  parameter int H     = 4,
  parameter int P     = 4,
  parameter int DW    = 16,
  parameter int M_LAT = 6,
  localparam int E    = B * H * P,
  localparam int F    = M_LAT + 2,
  localparam int IW   = (E > 1) ? $clog2(E) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [E*DW-1:0] y_flat,
  input  logic [E*DW-1:0] zg_flat,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic            done
);
  localparam int CW = $clog2(F + 1);
  localparam int TW = DW + IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(E - 1);
  localparam logic [CW:0]   F_L      = (CW + 1)'(F);

  state_e          state_q, state_d;
  logic [E*DW-1:0] y_q, y_d, zg_q, zg_d;
  logic [IW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [M_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IW:0]     tag_q [M_LAT];
  logic [IW:0]     tag_d [M_LAT];
  logic            issue, push, pop, credit_ok, fifo_empty;
  logic [CW-1:0]   fifo_cnt;
  logic [DW-1:0]   mul_a, mul_b, mul_p;
  logic [TW-1:0]   head;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = tag_vld_q[M_LAT-1];
  // Products already in flight hold a credit until they land in the FIFO
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (F_L + {{CW{1'b0}}, pop});
  assign mul_a     = y_q[issue_cnt_q*DW +: DW];
  assign mul_b     = zg_q[issue_cnt_q*DW +: DW];

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    y_d         = y_q;
    zg_d        = zg_q;
    issue       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          y_d         = y_flat;
          zg_d        = zg_flat;
          issue_cnt_d = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue       = 1'b1;
          issue_cnt_d = issue_cnt_q + IW'(1);
          if (issue_cnt_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (pop && out_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d   = inflight_q + CW'(issue) - CW'(push);
    tag_vld_d    = tag_vld_q << 1;
    tag_vld_d[0] = issue;
    tag_d[0]     = {issue_cnt_q, issue_cnt_q == LAST_IDX};
    for (int i = 1; i < M_LAT; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      inflight_q  <= '0;
      tag_vld_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= inflight_d;
      tag_vld_q   <= tag_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    y_q   <= y_d;
    zg_q  <= zg_d;
    tag_q <= tag_d;
  end

  fp16_mul #(.M_LAT(M_LAT)) u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  y_gate_fifo #(.DEPTH(F), .W(TW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({mul_p, tag_q[M_LAT-1]}),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign out_data = out_valid ? head[TW-1 -: DW] : DW'(POS_ZERO);
  assign out_idx  = out_valid ? head[IW:1] : '0;
  assign out_last = out_valid && head[0];
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
endmodule

// File: tb/tb_y_gate_stream.sv
// Directed bench for y_gate_stream: table of fp16 products plus multi-cycle
// sequences for latency, backpressure, ignored start, reset and back-to-back.
module tb_y_gate_stream;
  localparam int B = 1, H = 4, P = 4, DW = 16, M_LAT = 6;
  localparam int E = B * H * P;
  localparam int F = M_LAT + 2;
  localparam int IW = $clog2(E);

  logic            clk = 1'b0;
  logic            rst, start, out_ready;
  logic [E*DW-1:0] y_flat, zg_flat;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            out_valid, out_last, busy, done;

  always #5 clk = ~clk;

  y_gate_stream #(.B(B), .H(H), .P(P), .DW(DW), .M_LAT(M_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .y_flat    (y_flat),
    .zg_flat   (zg_flat),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [15:0] y;
    logic [15:0] zg;
    logic [15:0] prod;
  } vec_t;

  vec_t            tbl [E];
  logic [15:0]     expd [E];
  logic [E*DW-1:0] yv, zv;
  int checks = 0, errors = 0;
  int cyc = 0, s_cyc = 0, first_v = -1, done_cyc = -1, max_cnt = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_pass(input logic [E*DW-1:0] ys, input logic [E*DW-1:0] zs);
    step();
    start   = 1'b1;
    y_flat  = ys;
    zg_flat = zs;
    s_cyc   = cyc;
    step();
    start   = 1'b0;
    y_flat  = '1;
    zg_flat = '1;
  endtask

  // mode 0: ready held high; mode 1: toggle, then 20 cycles low mid-pass
  task automatic run_pass(input int mode, input int stop_after, input int restart_rel);
    int          n = 0, last_hs = -1, rel;
    logic        held = 1'b0, fin = 1'b0;
    logic [DW-1:0] hd = '0;
    logic [IW-1:0] hi = '0;
    logic        hl = 1'b0;
    first_v  = -1;
    done_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      rel = cyc - s_cyc;
      if (mode == 1) out_ready = (rel >= 16 && rel < 36) ? 1'b0 : (rel % 2 == 1);
      else           out_ready = 1'b1;
      if (restart_rel > 0) begin
        start = (rel == restart_rel);
        if (rel == restart_rel) y_flat = {E{16'h4400}};
      end
      if (held) begin
        chk("hold_data", out_data, hd);
        chk("hold_idx", out_idx, hi);
        chk("hold_last", out_last, hl);
      end
      if (int'(dut.fifo_cnt) > max_cnt) max_cnt = int'(dut.fifo_cnt);
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) begin
        chk("done_after_last_hs", cyc, last_hs + 1);
        done_cyc = cyc;
        fin = 1'b1;
        break;
      end
      if (out_valid && out_ready) begin
        if (n >= E) chk("extra_handshake", n, E - 1);
        else begin
          chk($sformatf("data[%0d]", n), out_data, expd[n]);
          chk($sformatf("idx[%0d]", n), out_idx, n);
          chk($sformatf("last[%0d]", n), out_last, (n == E - 1));
        end
        n++;
        if (n == E) last_hs = cyc;
        if (n == stop_after) begin
          fin = 1'b1;
          break;
        end
      end
      held = out_valid && !out_ready;
      hd   = out_data;
      hi   = out_idx;
      hl   = out_last;
      step();
    end
    start = 1'b0;
    chk("pass_complete", fin, 1);
    chk("handshakes", n, (stop_after > 0) ? stop_after : E);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{16'h3C00, 16'h4000, 16'h4000};
    tbl[1]  = '{16'h3E00, 16'hC000, 16'hC200};
    tbl[2]  = '{16'h3E00, 16'h8000, 16'h8000};
    tbl[3]  = '{16'h0000, 16'hC000, 16'h8000};
    tbl[4]  = '{16'h7C00, 16'h4000, 16'h7C00};
    tbl[5]  = '{16'h7E00, 16'h3C00, 16'h7E00};
    tbl[6]  = '{16'h7C00, 16'h0000, 16'h7E00};
    tbl[7]  = '{16'h3800, 16'h3800, 16'h3400};
    tbl[8]  = '{16'h7BFF, 16'h4000, 16'h7C00};
    tbl[9]  = '{16'hBC00, 16'hBC00, 16'h3C00};
    tbl[10] = '{16'h0400, 16'h3800, 16'h0200};
    tbl[11] = '{16'h0001, 16'h4000, 16'h0002};
    tbl[12] = '{16'h3E00, 16'h3C01, 16'h3E02};
    tbl[13] = '{16'h3E00, 16'h3C03, 16'h3E04};
    tbl[14] = '{16'hFC00, 16'h4000, 16'hFC00};
    tbl[15] = '{16'h3C00, 16'hBC00, 16'hBC00};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; y_flat = '0; zg_flat = '0;
    step(); step();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();

    // Basic pass with latency checks
    for (int k = 0; k < E; k++) expd[k] = 16'h4000;
    start_pass({E{16'h3C00}}, {E{16'h4000}});
    chk("busy_after_start", busy, 1);
    run_pass(0, 0, 0);
    chk("first_valid_lat", first_v - s_cyc, M_LAT + 2);
    chk("done_lat", done_cyc - s_cyc, M_LAT + 2 + E);
    step();
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);

    // Values: 1.5 * -2 with a negative-zero gate at index 5
    for (int k = 0; k < E; k++) begin
      yv[k*DW +: DW] = 16'h3E00;
      zv[k*DW +: DW] = (k == 5) ? 16'h8000 : 16'hC000;
      expd[k]        = (k == 5) ? 16'h8000 : 16'hC200;
    end
    start_pass(yv, zv);
    run_pass(0, 0, 0);

    // Table of arithmetic corners under backpressure
    for (int k = 0; k < E; k++) begin
      yv[k*DW +: DW] = tbl[k].y;
      zv[k*DW +: DW] = tbl[k].zg;
      expd[k]        = tbl[k].prod;
    end
    max_cnt = 0;
    start_pass(yv, zv);
    run_pass(1, 0, 0);
    chk("fifo_count_le_F", (max_cnt <= F), 1);

    // Second start during RUN is ignored
    for (int k = 0; k < E; k++) expd[k] = 16'h4600;
    start_pass({E{16'h4000}}, {E{16'h4200}});
    run_pass(0, 0, 4);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid || busy || done) bad++;
    end
    chk("no_second_pass", bad, 0);

    // Reset after the 7th handshake
    for (int k = 0; k < E; k++) expd[k] = 16'h4000;
    start_pass({E{16'h3C00}}, {E{16'h4000}});
    run_pass(0, 7, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data", out_data, 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || out_valid) bad++;
    end
    chk("rst_mid_no_done", bad, 0);

    // Fresh pass after reset, then back-to-back start one cycle after done
    for (int k = 0; k < E; k++) begin
      yv[k*DW +: DW] = tbl[k].y;
      zv[k*DW +: DW] = tbl[k].zg;
      expd[k]        = tbl[k].prod;
    end
    start_pass(yv, zv);
    run_pass(0, 0, 0);
    chk("fresh_done_lat", done_cyc - s_cyc, M_LAT + 2 + E);
    for (int k = 0; k < E; k++) begin
      yv[k*DW +: DW] = 16'h3E00;
      zv[k*DW +: DW] = (k == 5) ? 16'h8000 : 16'hC000;
      expd[k]        = (k == 5) ? 16'h8000 : 16'hC200;
    end
    start_pass(yv, zv);
    chk("b2b_busy", busy, 1);
    run_pass(0, 0, 0);
    chk("b2b_first_valid_lat", first_v - s_cyc, M_LAT + 2);
    chk("b2b_done_lat", done_cyc - s_cyc, M_LAT + 2 + E);
    step();
    chk("b2b_busy_after_done", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
